// File: rtl/encrypt_v1_pkg.sv
// encrypt_v1_pkg: shared widths, FSM state type and PRESENT primitives
// (4-bit S-box and 64-bit pLayer) for the encrypt_v1 PRESENT-80 core.
// No ports; imported by encrypt_v1 and encrypt_v1_round.
package encrypt_v1_pkg;

  localparam int N_K = 80;  // cipher key width
  localparam int N_B = 64;  // block width
  localparam int N_R = 31;  // number of full rounds

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  // Bit j goes to (16*j) mod 63; bit 63 is a fixed point.
  function automatic logic [N_B-1:0] player(input logic [N_B-1:0] x);
    logic [N_B-1:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) begin
      y[6'((16 * j) % 63)] = x[6'(j)];
    end
    y[63] = x[63];
    return y;
  endfunction

endpackage

// File: rtl/encrypt_v1_round.sv
// encrypt_v1_round: one combinational PRESENT-80 round.
// Ports:
//   st_i  [63:0] current state      st_o [63:0] state after key-add, S-box, pLayer
//   kr_i  [79:0] current key reg    kr_o [79:0] key register after update
//   rnd_i [4:0]  round index i (1..31), XORed into key bits [19:15]
module encrypt_v1_round
  import encrypt_v1_pkg::*;
(
  input  logic [N_B-1:0] st_i,
  input  logic [N_K-1:0] kr_i,
  input  logic [4:0]     rnd_i,
  output logic [N_B-1:0] st_o,
  output logic [N_K-1:0] kr_o
);

  logic [N_B-1:0] t;
  logic [N_B-1:0] s;
  logic [N_K-1:0] rot;

  always_comb begin
    t = st_i ^ kr_i[79:16];
    s = '0;
    for (int n = 0; n < 16; n++) begin
      s[6'(4 * n) +: 4] = sbox4(t[6'(4 * n) +: 4]);
    end
    st_o = player(s);

    // Rotate left by 61 is the same as rotate right by 19 on 80 bits.
    rot = {kr_i[18:0], kr_i[79:19]};
    kr_o = rot;
    kr_o[79:76] = sbox4(rot[79:76]);
    kr_o[19:15] = rot[19:15] ^ rnd_i;
  end

endmodule

// File: rtl/encrypt_v1.sv
// encrypt_v1: iterative PRESENT-80 encryption, one round per clock,
// four-phase req/ack handshake. Ciphertext valid 31 cycles after the start edge.
// Ports:
//   clk, rst (sync, active-high)
//   req  in  : start request, held until ack
//   ack  out : result valid, held until req falls
//   k    in  [79:0] key, m in [63:0] plaintext (sampled on the start edge only)
//   c    out [63:0] registered ciphertext
//   rk   out [79:0] key register (K32 in DONE); only when ENCRYPT_V1_RK_OUT_EN is defined
module encrypt_v1
  import encrypt_v1_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  output logic           ack,
  input  logic [N_K-1:0] k,
  input  logic [N_B-1:0] m,
  output logic [N_B-1:0] c
`ifdef ENCRYPT_V1_RK_OUT_EN
  ,
  output logic [N_K-1:0] rk
`endif
);

  state_e         state_q, state_d;
  logic [N_B-1:0] st_q, st_d;
  logic [N_K-1:0] kr_q, kr_d;
  logic [4:0]     rnd_q, rnd_d;
  logic [N_B-1:0] c_q, c_d;
  logic           ack_q, ack_d;

  logic [N_B-1:0] st_nxt;
  logic [N_K-1:0] kr_nxt;

  encrypt_v1_round u_round (
    .st_i  (st_q),
    .kr_i  (kr_q),
    .rnd_i (rnd_q),
    .st_o  (st_nxt),
    .kr_o  (kr_nxt)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    kr_d    = kr_q;
    rnd_d   = rnd_q;
    c_d     = c_q;
    ack_d   = ack_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          st_d    = m;
          kr_d    = k;
          rnd_d   = 5'd1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        st_d  = st_nxt;
        kr_d  = kr_nxt;
        rnd_d = rnd_q + 5'd1;
        // Last round: fold in the final whitening key K32 on the same edge.
        if (rnd_q == 5'(N_R)) begin
          c_d     = st_nxt ^ kr_nxt[79:16];
          ack_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      kr_q    <= '0;
      rnd_q   <= '0;
      c_q     <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      kr_q    <= kr_d;
      rnd_q   <= rnd_d;
      c_q     <= c_d;
      ack_q   <= ack_d;
    end
  end

  assign c   = c_q;
  assign ack = ack_q;
`ifdef ENCRYPT_V1_RK_OUT_EN
  assign rk  = kr_q;
`endif

endmodule

// File: tb/tb_encrypt_v1.sv
// tb_encrypt_v1: directed test of the encrypt_v1 PRESENT-80 core against the
// published PRESENT-80 test vectors, plus handshake and reset behaviour.
module tb_encrypt_v1;

  logic        clk;
  logic        rst;
  logic        req;
  logic        ack;
  logic [79:0] k;
  logic [63:0] m;
  logic [63:0] c;
`ifdef ENCRYPT_V1_RK_OUT_EN
  logic [79:0] rk;
`endif

  int vec_cnt;
  int err_cnt;

  localparam logic [79:0] K_ZERO = 80'h0;
  localparam logic [79:0] K_ONES = {80{1'b1}};
  localparam logic [63:0] M_ZERO = 64'h0;
  localparam logic [63:0] M_ONES = {64{1'b1}};

  encrypt_v1 dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .ack (ack),
    .k   (k),
    .m   (m),
    .c   (c)
`ifdef ENCRYPT_V1_RK_OUT_EN
    ,
    .rk  (rk)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a run; optionally scramble k/m mid-RUN. Returns the cycle count
  // from the start edge to ack (capped at 40).
  task automatic start_and_wait(input logic [79:0] kk, input logic [63:0] mm,
                                input bit scramble, output int lat);
    @(negedge clk);
    k   = kk;
    m   = mm;
    req = 1'b1;
    @(posedge clk);  // start edge E0
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble && lat == 5) begin
        k = ~kk ^ 80'h1234_5678_9ABC_DEF0_1357;
        m = ~mm ^ 64'hA5A5_0F0F_3C3C_9696;
      end
    end while (!ack && lat < 40);
  endtask

  task automatic drop_req();
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    check("ack_falls", {79'h0, ack}, 80'h0);
  endtask

  task automatic run_vector(input string tag, input logic [79:0] kk, input logic [63:0] mm,
                            input logic [63:0] exp, input bit scramble);
    int lat;
    start_and_wait(kk, mm, scramble, lat);
    check({tag, "_lat"}, 80'(lat), 80'd31);
    check({tag, "_c"}, {16'h0, c}, {16'h0, exp});
  endtask

  initial begin
    int lat;
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    req = 1'b0;
    k   = '0;
    m   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {79'h0, ack}, 80'h0);
    check("rst_c", {16'h0, c}, 80'h0);
`ifdef ENCRYPT_V1_RK_OUT_EN
    check("rst_rk", rk, 80'h0);
`endif
    rst = 1'b0;

    // Four standard vectors
    run_vector("v00", K_ZERO, M_ZERO, 64'h5579c1387b228445, 1'b0);
    drop_req();
    run_vector("vf0", K_ONES, M_ZERO, 64'he72c46c0f5945049, 1'b0);
    drop_req();
    run_vector("v0f", K_ZERO, M_ONES, 64'ha112ffc72f68417b, 1'b0);
    drop_req();
    // c holds the last result back in IDLE
    check("c_held_idle", {16'h0, c}, {16'h0, 64'ha112ffc72f68417b});
    run_vector("vff", K_ONES, M_ONES, 64'h3333dcd3213210d2, 1'b0);

    // Hold req in DONE: ack and c stay put
    repeat (5) @(posedge clk);
    #1;
    check("hold_ack", {79'h0, ack}, 80'h1);
    check("hold_c", {16'h0, c}, {16'h0, 64'h3333dcd3213210d2});
    drop_req();

    // Inputs changed mid-RUN have no effect
    run_vector("scr", K_ZERO, M_ZERO, 64'h5579c1387b228445, 1'b1);
    drop_req();

    // Reset around round 10 aborts the run
    @(negedge clk);
    k   = K_ONES;
    m   = M_ZERO;
    req = 1'b1;
    @(posedge clk);            // E0
    repeat (9) @(posedge clk); // E1..E9, round 10 is next
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ack", {79'h0, ack}, 80'h0);
    check("abort_c", {16'h0, c}, 80'h0);
`ifdef ENCRYPT_V1_RK_OUT_EN
    check("abort_rk", rk, 80'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    check("abort_no_ack", {79'h0, ack}, 80'h0);

    // A fresh run after reset still works
    start_and_wait(K_ONES, M_ZERO, 1'b0, lat);
    check("post_lat", 80'(lat), 80'd31);
    check("post_c", {16'h0, c}, {16'h0, 64'he72c46c0f5945049});
    drop_req();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
